// File: rtl/output_pattern_sequencer_pkg.sv
// Shared definitions for the output pattern sequencer.
//   - command op codes carried in cmd_byte[5:4]
//   - CTRL sub-codes carried in cmd_byte[7:6]
//   - sequencer FSM state encoding
//   - frame geometry: NCH channels x NIB bits = FRAME_W
package output_pattern_sequencer_pkg;

   localparam int NCH     = 4;
   localparam int NIB     = 4;
   localparam int FRAME_W = NCH * NIB;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'b00,
      OP_READ   = 2'b01,
      OP_COMMIT = 2'b10,
      OP_CTRL   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SUB_STOP     = 2'b00,
      SUB_RUN_LOOP = 2'b01,
      SUB_RUN_ONCE = 2'b10,
      SUB_CLEAR    = 2'b11
   } ctrl_sub_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_HOLD = 2'b10
   } state_e;

   // Bit offset of channel ch's nibble inside a frame.
   function automatic logic [3:0] nib_lsb(input logic [1:0] ch);
      return {ch, 2'b00};
   endfunction

endpackage

// File: rtl/output_pattern_sequencer_pattern_table.sv
// Committed-frame storage for the output pattern sequencer.
// DEPTH x FRAME_W register file, one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset; the
// sequencer never reads an entry that has not been committed.
//   ico_clk  in   clock (write port)
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data (one frame)
//   raddr    in   read address
//   rdata    out  frame at raddr (combinational)
module output_pattern_sequencer_pattern_table
   import output_pattern_sequencer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               ico_clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [FRAME_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [FRAME_W-1:0] rdata
);

   logic [FRAME_W-1:0] mem_q [DEPTH];

   always_ff @(posedge ico_clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/output_pattern_sequencer.sv
// Output pattern sequencer: owns the 4-channel x 4-bit live nibble table
// feeding the output pin scanner. Decodes SPI command bytes, stages
// nibbles, commits frames to the pattern table and replays them.
//   ico_clk      in   sole clock, posedge
//   ico_rst_n    in   async active-low reset
//   cmd_valid    in   one-cycle strobe per completed SPI byte
//   cmd_byte     in   [7:6] ch/sub, [5:4] op, [3:0] data
//   live         out  channel k nibble at [4k+3:4k]
//   frame_sync   out  pulse in the cycle live first shows a table frame
//   rsp_valid    out  read-back strobe, cycle after a READ
//   rsp_byte     out  {cmd_byte[7:4], live nibble of addressed channel}
//   running      out  high in LOAD/HOLD
//   frame_count  out  committed frames 0..DEPTH
//   overflow     out  sticky, commit attempted while table full
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | live tracks the staging registers
// LOAD   | one cycle: live <= table[rd_ptr], frame_sync, timer reload
// HOLD   | count down the remainder of the frame period
module output_pattern_sequencer
   import output_pattern_sequencer_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int PRESCALE_SH = 10
) (
   input  logic                     ico_clk,
   input  logic                     ico_rst_n,
   input  logic                     cmd_valid,
   input  logic [7:0]               cmd_byte,
   output logic [FRAME_W-1:0]       live,
   output logic                     frame_sync,
   output logic                     rsp_valid,
   output logic [7:0]               rsp_byte,
   output logic                     running,
   output logic [$clog2(DEPTH):0]   frame_count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = 4 + PRESCALE_SH;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [TW-1:0] SH_MASK  = TW'((1 << PRESCALE_SH) - 1);

   state_e             state_q, state_d;
   logic [FRAME_W-1:0] stage_q, stage_d;
   logic [FRAME_W-1:0] live_q, live_d;
   logic               frame_sync_q, frame_sync_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [7:0]         rsp_byte_q, rsp_byte_d;
   logic [CW-1:0]      fc_q, fc_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [3:0]         p_q, p_d;
   logic               loop_q, loop_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               overflow_q, overflow_d;

   logic [1:0]         cmd_ch;
   op_e                cmd_op;
   ctrl_sub_e          cmd_sub;
   logic [3:0]         cmd_data;
   logic               is_write, is_read, is_commit, is_ctrl;

   logic [TW-1:0]      period_m1;
   logic               last_frame;
   logic               frame_done;
   logic               load_now;
   logic               table_we;
   logic [FRAME_W-1:0] table_rdata;

   assign cmd_ch    = cmd_byte[7:6];
   assign cmd_op    = op_e'(cmd_byte[5:4]);
   assign cmd_sub   = ctrl_sub_e'(cmd_byte[7:6]);
   assign cmd_data  = cmd_byte[3:0];
   assign is_write  = cmd_valid && (cmd_op == OP_WRITE);
   assign is_read   = cmd_valid && (cmd_op == OP_READ);
   assign is_commit = cmd_valid && (cmd_op == OP_COMMIT);
   assign is_ctrl   = cmd_valid && (cmd_op == OP_CTRL);

   // (P+1) << SH minus one, built without an adder.
   assign period_m1  = (TW'(p_q) << PRESCALE_SH) | SH_MASK;
   assign last_frame = (({1'b0, rd_ptr_q} + CW'(1)) >= fc_q);

   output_pattern_sequencer_pattern_table #(
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_table (
      .ico_clk (ico_clk),
      .we      (table_we),
      .waddr   (wr_ptr_q),
      .wdata   (stage_q),
      .raddr   (rd_ptr_q),
      .rdata   (table_rdata)
   );

   // The LOAD cycle is the first cycle of the frame period, so HOLD leaves
   // when the timer is about to expire (timer==1); a period of one cycle
   // never enters HOLD at all. This keeps frame_sync pulses exactly one
   // period apart.
   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      timer_d    = timer_q;
      loop_d     = loop_q;
      load_now   = 1'b0;
      frame_done = 1'b0;

      case (state_q)
         S_LOAD: begin
            load_now   = 1'b1;
            timer_d    = period_m1;
            frame_done = (period_m1 == '0);
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            timer_d    = timer_q - TW'(1);
            frame_done = (timer_q == TW'(1));
         end
         default: ;
      endcase

      if (frame_done) begin
         if (!last_frame) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            state_d  = S_LOAD;
         end else begin
            rd_ptr_d = '0;
            state_d  = loop_q ? S_LOAD : S_IDLE;
         end
      end

      // Commands override the playback step.
      if (is_ctrl) begin
         case (cmd_sub)
            SUB_STOP, SUB_CLEAR: begin
               state_d  = S_IDLE;
               rd_ptr_d = '0;
               load_now = 1'b0;
            end
            default: begin
               if (fc_q != '0) begin
                  state_d  = S_LOAD;
                  rd_ptr_d = '0;
                  loop_d   = (cmd_sub == SUB_RUN_LOOP);
                  load_now = 1'b0;
               end
            end
         endcase
      end
   end

   always_comb begin
      stage_d     = stage_q;
      rsp_valid_d = is_read;
      rsp_byte_d  = rsp_byte_q;
      fc_d        = fc_q;
      wr_ptr_d    = wr_ptr_q;
      overflow_d  = overflow_q;
      p_d         = p_q;
      table_we    = 1'b0;

      if (is_write) begin
         stage_d[nib_lsb(cmd_ch) +: NIB] = cmd_data;
      end

      if (is_read) begin
         rsp_byte_d = {cmd_byte[7:4], live_q[nib_lsb(cmd_ch) +: NIB]};
      end

      if (is_commit) begin
         if (fc_q == FULL_CNT) begin
            overflow_d = 1'b1;
         end else begin
            table_we = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            fc_d     = fc_q + CW'(1);
         end
      end

      if (is_ctrl) begin
         p_d = cmd_data;
         if (cmd_sub == SUB_CLEAR) begin
            fc_d       = '0;
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
         end
      end

      // A frame loaded on the final step of a one-cycle RUN_ONCE still
      // shows for a cycle; IDLE then pulls live back to stage.
      if (load_now) begin
         live_d = table_rdata;
      end else if (state_d == S_IDLE) begin
         live_d = stage_d;
      end else begin
         live_d = live_q;
      end

      frame_sync_d = load_now;
   end

   always_ff @(posedge ico_clk or negedge ico_rst_n) begin
      if (!ico_rst_n) begin
         state_q      <= S_IDLE;
         stage_q      <= '0;
         live_q       <= '0;
         frame_sync_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_byte_q   <= '0;
         fc_q         <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         p_q          <= '0;
         loop_q       <= 1'b0;
         timer_q      <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         stage_q      <= stage_d;
         live_q       <= live_d;
         frame_sync_q <= frame_sync_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_byte_q   <= rsp_byte_d;
         fc_q         <= fc_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         p_q          <= p_d;
         loop_q       <= loop_d;
         timer_q      <= timer_d;
         overflow_q   <= overflow_d;
      end
   end

   assign live        = live_q;
   assign frame_sync  = frame_sync_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_byte    = rsp_byte_q;
   assign running     = (state_q != S_IDLE);
   assign frame_count = fc_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_output_pattern_sequencer.sv
// Directed bench for output_pattern_sequencer with DEPTH=4, PRESCALE_SH=0.
// Command bytes: [7:6] ch/sub, [5:4] op (00 WRITE, 01 READ, 10 COMMIT,
// 11 CTRL), [3:0] data. Inputs change and outputs are sampled on negedge.
module tb_output_pattern_sequencer;

   logic        ico_clk;
   logic        ico_rst_n;
   logic        cmd_valid;
   logic [7:0]  cmd_byte;
   logic [15:0] live;
   logic        frame_sync;
   logic        rsp_valid;
   logic [7:0]  rsp_byte;
   logic        running;
   logic [2:0]  frame_count;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   output_pattern_sequencer #(
      .DEPTH       (4),
      .PRESCALE_SH (0)
   ) dut (
      .ico_clk     (ico_clk),
      .ico_rst_n   (ico_rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_byte    (cmd_byte),
      .live        (live),
      .frame_sync  (frame_sync),
      .rsp_valid   (rsp_valid),
      .rsp_byte    (rsp_byte),
      .running     (running),
      .frame_count (frame_count),
      .overflow    (overflow)
   );

   initial begin
      ico_clk = 1'b0;
      forever #5 ico_clk = ~ico_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one command byte for one cycle; returns at the negedge right
   // after the capturing posedge, where its effect is visible.
   task automatic send(input logic [7:0] b);
      @(negedge ico_clk);
      cmd_valid = 1'b1;
      cmd_byte  = b;
      @(negedge ico_clk);
      cmd_valid = 1'b0;
      cmd_byte  = 8'h00;
   endtask

   logic [15:0] once_live [5];
   logic        once_fs   [5];
   logic        once_run  [5];
   logic [15:0] fast_live [5];

   initial begin
      once_live = '{16'h1111, 16'h1111, 16'h2222, 16'h2225, 16'h2225};
      once_fs   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      once_run  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      fast_live = '{16'h2225, 16'h2226, 16'h2227, 16'h2228, 16'h2225};

      cmd_valid = 1'b0;
      cmd_byte  = 8'h00;
      ico_rst_n = 1'b1;
      #1 ico_rst_n = 1'b0;
      #2;
      chk("rst_live", 32'(live), 32'h0);
      chk("rst_fs", 32'(frame_sync), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_byte", 32'(rsp_byte), 32'h0);
      chk("rst_running", 32'(running), 32'h0);
      chk("rst_fc", 32'(frame_count), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      repeat (2) @(negedge ico_clk);
      ico_rst_n = 1'b1;

      // Idle: live follows staging writes; READ reports live.
      send(8'h0A);
      chk("wr_ch0_live", 32'(live), 32'h000A);
      send(8'h45);
      chk("wr_ch1_live", 32'(live), 32'h005A);
      send(8'h50);
      chk("rd_ch1_valid", 32'(rsp_valid), 32'h1);
      chk("rd_ch1_byte", 32'(rsp_byte), 32'h55);
      @(negedge ico_clk);
      chk("rd_valid_drop", 32'(rsp_valid), 32'h0);
      send(8'h10);
      chk("rd_ch0_byte", 32'(rsp_byte), 32'h1A);

      // Two frames: 0x1111, 0x2222.
      send(8'h01); send(8'h41); send(8'h81); send(8'hC1);
      chk("stage_1111", 32'(live), 32'h1111);
      send(8'h20);
      chk("commit1_fc", 32'(frame_count), 32'h1);
      send(8'h02); send(8'h42); send(8'h82); send(8'hC2);
      send(8'h20);
      chk("commit2_fc", 32'(frame_count), 32'h2);
      chk("idle_live_2222", 32'(live), 32'h2222);

      // RUN_LOOP, P=3: frame every 4 cycles.
      send(8'h73);
      chk("loop_running", 32'(running), 32'h1);
      chk("loop_fs0", 32'(frame_sync), 32'h0);
      chk("loop_live0", 32'(live), 32'h2222);
      for (int c = 1; c <= 12; c++) begin
         @(negedge ico_clk);
         chk($sformatf("loop_fs_c%0d", c), 32'(frame_sync), 32'((c % 4) == 1));
         chk($sformatf("loop_live_c%0d", c), 32'(live),
             ((((c - 1) / 4) % 2) == 0) ? 32'h1111 : 32'h2222);
      end
      @(negedge ico_clk);
      chk("hold_running", 32'(running), 32'h1);

      // STOP mid-HOLD.
      send(8'h30);
      chk("stop_running", 32'(running), 32'h0);
      chk("stop_live", 32'(live), 32'h2222);
      chk("stop_fs", 32'(frame_sync), 32'h0);
      @(negedge ico_clk);
      chk("stop_fs_after", 32'(frame_sync), 32'h0);

      // RUN_ONCE, P=1, stage differs from both frames.
      send(8'h05);
      chk("stage_2225", 32'(live), 32'h2225);
      send(8'hB1);
      for (int c = 0; c < 5; c++) begin
         @(negedge ico_clk);
         chk($sformatf("once_fs_c%0d", c + 1), 32'(frame_sync), 32'(once_fs[c]));
         chk($sformatf("once_live_c%0d", c + 1), 32'(live), 32'(once_live[c]));
         chk($sformatf("once_run_c%0d", c + 1), 32'(running), 32'(once_run[c]));
      end

      // CLEAR, then fill to DEPTH and overflow.
      send(8'hF0);
      chk("clear_fc", 32'(frame_count), 32'h0);
      send(8'h20);
      send(8'h06); send(8'h20);
      send(8'h07); send(8'h20);
      send(8'h08); send(8'h20);
      chk("full_fc", 32'(frame_count), 32'h4);
      chk("full_ovf0", 32'(overflow), 32'h0);
      send(8'h09); send(8'h20);
      chk("ovf_fc", 32'(frame_count), 32'h4);
      chk("ovf_flag", 32'(overflow), 32'h1);

      // RUN_LOOP, P=0: one frame per cycle; entry 0 must be untouched.
      send(8'h70);
      for (int c = 0; c < 5; c++) begin
         @(negedge ico_clk);
         chk($sformatf("fast_fs_c%0d", c + 1), 32'(frame_sync), 32'h1);
         chk($sformatf("fast_live_c%0d", c + 1), 32'(live), 32'(fast_live[c]));
      end
      send(8'h30);
      chk("stop2_live", 32'(live), 32'h2229);
      chk("stop2_running", 32'(running), 32'h0);
      send(8'hF0);
      chk("clear2_fc", 32'(frame_count), 32'h0);
      chk("clear2_ovf", 32'(overflow), 32'h0);

      // RUN with empty table is ignored.
      send(8'h70);
      chk("empty_running", 32'(running), 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge ico_clk);
         chk($sformatf("empty_fs_c%0d", c), 32'(frame_sync), 32'h0);
         chk($sformatf("empty_run_c%0d", c), 32'(running), 32'h0);
      end

      // Async reset in the middle of HOLD.
      send(8'h20);
      send(8'h7F);
      @(negedge ico_clk);
      chk("pre_rst_fs", 32'(frame_sync), 32'h1);
      @(negedge ico_clk);
      @(negedge ico_clk);
      chk("pre_rst_running", 32'(running), 32'h1);
      #2 ico_rst_n = 1'b0;
      #1;
      chk("async_live", 32'(live), 32'h0);
      chk("async_running", 32'(running), 32'h0);
      chk("async_fc", 32'(frame_count), 32'h0);
      chk("async_fs", 32'(frame_sync), 32'h0);
      chk("async_rsp_byte", 32'(rsp_byte), 32'h0);
      @(negedge ico_clk);
      ico_rst_n = 1'b1;
      @(negedge ico_clk);
      chk("post_rst_live", 32'(live), 32'h0);
      chk("post_rst_running", 32'(running), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
